// File: rtl/i8088_bus_pkg.sv
// Shared types and constants for the 8088-style minimum-mode bus master.
package i8088_bus_pkg;

  // One-hot bus cycle state
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    TW   = 6'b010000,
    T4   = 6'b100000
  } bus_state_e;

  // Bus cycle type, encoded as {io, wr}
  typedef enum logic [1:0] {
    MEM_RD = 2'b00,
    MEM_WR = 2'b01,
    IO_RD  = 2'b10,
    IO_WR  = 2'b11
  } cycle_type_e;

  // Idle levels of the bus strobes
  localparam logic STROBE_OFF = 1'b1;
  localparam logic ALE_OFF    = 1'b0;

  // Wait counter width; large enough for MAX_WAIT up to 255
  localparam int unsigned WAIT_CNT_W = 8;

  function automatic cycle_type_e cycle_type(input logic io, input logic wr);
    return cycle_type_e'({io, wr});
  endfunction

  function automatic logic is_write(input cycle_type_e t);
    return (t == MEM_WR) || (t == IO_WR);
  endfunction

  function automatic logic is_io(input cycle_type_e t);
    return (t == IO_RD) || (t == IO_WR);
  endfunction

endpackage

// File: rtl/i8088_wait_timer.sv
// Wait-state counter: load to 1 on entry to Tw, count up, flag MAX_WAIT.
module i8088_wait_timer
  import i8088_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam int unsigned CNT_W = WAIT_CNT_W;

  logic [CNT_W-1:0] cnt;

  // Counter with registered terminal-count flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      cnt <= CNT_W'(1);
      tc  <= (MAX_WAIT == 1);
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
      tc  <= ((cnt + CNT_W'(1)) == CNT_W'(MAX_WAIT));
    end
  end

endmodule

// File: rtl/i8088_bus_cycle_gen.sv
// 8088 minimum-mode bus cycle generator: T1/T2/T3/Tw/T4 with wait timeout.
module i8088_bus_cycle_gen
  import i8088_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ALE,
  output logic              RD_N,
  output logic              WR_N,
  output logic              IOM,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA,
  input  logic              READY
);

  bus_state_e        state;
  bus_state_e        next_state;
  cycle_type_e       cyc_q;
  logic [DATA_W-1:0] wdata_q;
  logic              data_oe;
  logic              accept;
  logic              wait_tc;
  logic              timeout;
  logic              sample_rd;
  logic              ale_d;
  logic              rd_n_d;
  logic              wr_n_d;
  logic              oe_d;
  logic              rsp_valid_d;

  // Ready is a decode of the state flops, forced low while in reset
  assign req_ready = RESET_N && ((state == IDLE) || (state == T4));
  assign accept    = req_valid && req_ready;
  assign timeout   = (state == TW) && !READY && wait_tc;
  assign sample_rd = !is_write(cyc_q) && ((state == T3) || (state == TW)) && READY;
  assign IOM       = is_io(cyc_q);
  assign DATA      = data_oe ? wdata_q : {DATA_W{1'bz}};

  i8088_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk   (CLK),
    .rst_n (RESET_N),
    .load  ((state == T3) && !READY),
    .inc   (state == TW),
    .tc    (wait_tc)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; READY only matters in T3 and Tw
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = T1;
      T1:      next_state = T2;
      T2:      next_state = T3;
      T3:      next_state = READY ? T4 : TW;
      TW:      if (READY || wait_tc) next_state = T4;
      T4:      next_state = accept ? T1 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so strobes come straight off flops
  always_comb begin
    ale_d       = ALE_OFF;
    rd_n_d      = STROBE_OFF;
    wr_n_d      = STROBE_OFF;
    oe_d        = 1'b0;
    rsp_valid_d = 1'b0;
    case (next_state)
      T1: ale_d = 1'b1;
      T2, T3, TW: begin
        if (is_write(cyc_q)) begin
          wr_n_d = 1'b0;
          oe_d   = 1'b1;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      T4: begin
        oe_d        = is_write(cyc_q);
        rsp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture on accept; ADDR and cycle type hold through T4
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc_q   <= MEM_RD;
      ADDR    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cyc_q   <= cycle_type(req_io, req_wr);
      ADDR    <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Registered strobes, data enable and response
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ALE       <= ALE_OFF;
      RD_N      <= STROBE_OFF;
      WR_N      <= STROBE_OFF;
      data_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      ALE       <= ale_d;
      RD_N      <= rd_n_d;
      WR_N      <= wr_n_d;
      data_oe   <= oe_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= timeout;
      if (sample_rd)
        rsp_rdata <= DATA;
      else if (timeout && !is_write(cyc_q))
        rsp_rdata <= '0;
    end
  end

endmodule
